dir_fill_stage: RTL and testbench

Parametrised directional hole-fill stage in the post-processing chain, following LR-check/occlusion tagging and preceding the directional median/select stage. Each accepted disparity beat carries two flag bits. Valid pixels pass unchanged on all direction outputs. Flagged pixels get per-direction fill candidates:
- 0° (last valid pixel in the row, tracked internally);
- 45° / 90° / 135° (up-right / up / up-left neighbours from the line buffer).

Row-boundary handling, neighbour-flag qualification, a column counter and a per-frame hole counter are all built in.

---
 rtl/dir_fill_stage.sv | 177 +++++++++++++++++
 tb/tb_dir_fill_stage.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/dir_fill_stage.sv
// ============================================================================
// Module   : dir_fill_stage
// Purpose  : Directional hole-fill candidates (0/45/90/135 deg) for flagged
//            disparity beats, with column tracking and a per-frame hole count.
//            Optional macro DIR_FILL_LEFT_EN builds the 0 deg last-good tracker.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dir_fill_stage #(
   parameter int DWIDTH = 7,
   parameter int IMG_W  = 640,
   parameter int CNT_W  = 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clken,
   input  logic              enable,
   input  logic              frame_start,
   input  logic [DWIDTH+1:0] din,
   input  logic [DWIDTH+1:0] din_ur,
   input  logic [DWIDTH+1:0] din_up,
   input  logic [DWIDTH+1:0] din_ul,
   output logic [DWIDTH+1:0] dout_0,
   output logic [DWIDTH+1:0] dout_45,
   output logic [DWIDTH+1:0] dout_90,
   output logic [DWIDTH+1:0] dout_135,
   output logic              eol,
   output logic              valid,
   output logic [CNT_W-1:0]  hole_cnt
);

   localparam int                 c_col_w    = $clog2(IMG_W);
   localparam logic [c_col_w-1:0] c_last_col = c_col_w'(IMG_W - 1);
   localparam logic [CNT_W-1:0]   c_cnt_max  = {CNT_W{1'b1}};

   // combinational decode of the current beat
   logic                w_accept;
   logic [1:0]          w_flags;
   logic                w_good;
   logic [c_col_w-1:0]  w_col;
   logic                w_first;
   logic                w_last;
   logic [c_col_w-1:0]  w_col_next;
   logic [DWIDTH-1:0]   w_left;
   logic [DWIDTH-1:0]   w_fill_45;
   logic [DWIDTH-1:0]   w_fill_90;
   logic [DWIDTH-1:0]   w_fill_135;
   logic [DWIDTH+1:0]   w_d0;
   logic [DWIDTH+1:0]   w_d45;
   logic [DWIDTH+1:0]   w_d90;
   logic [DWIDTH+1:0]   w_d135;

   // pipeline state
   logic [c_col_w-1:0]  r_col;
   logic [CNT_W-1:0]    r_hole_cnt;
   logic [DWIDTH+1:0]   r_s1_0;
   logic [DWIDTH+1:0]   r_s1_45;
   logic [DWIDTH+1:0]   r_s1_90;
   logic [DWIDTH+1:0]   r_s1_135;
   logic                r_s1_eol;
   logic                r_s1_vld;
   logic [DWIDTH+1:0]   r_dout_0;
   logic [DWIDTH+1:0]   r_dout_45;
   logic [DWIDTH+1:0]   r_dout_90;
   logic [DWIDTH+1:0]   r_dout_135;
   logic                r_eol;
   logic                r_valid;

`ifdef DIR_FILL_LEFT_EN
   logic [DWIDTH-1:0]   r_last_good;
`endif

   always_comb begin
      w_accept   = clken & enable;
      w_flags    = din[DWIDTH+1:DWIDTH];
      w_good     = (w_flags == 2'b00);
      // a frame_start beat is forced to column 0 regardless of the counter
      w_col      = frame_start ? '0 : r_col;
      w_first    = (w_col == '0);
      w_last     = (w_col == c_last_col);
      w_col_next = w_last ? '0 : w_col + 1'b1;

`ifdef DIR_FILL_LEFT_EN
      w_left     = w_first ? '0 : r_last_good;
`else
      w_left     = '0;
`endif

      w_fill_45  = '0;
      w_fill_90  = '0;
      w_fill_135 = '0;
      if ((din_ur[DWIDTH+1:DWIDTH] == 2'b00) && !w_last)
         w_fill_45 = din_ur[DWIDTH-1:0];
      if (din_up[DWIDTH+1:DWIDTH] == 2'b00)
         w_fill_90 = din_up[DWIDTH-1:0];
      if ((din_ul[DWIDTH+1:DWIDTH] == 2'b00) && !w_first)
         w_fill_135 = din_ul[DWIDTH-1:0];

      if (w_good) begin
         w_d0   = din;
         w_d45  = din;
         w_d90  = din;
         w_d135 = din;
      end else begin
         w_d0   = {w_flags, w_left};
         w_d45  = {w_flags, w_fill_45};
         w_d90  = {w_flags, w_fill_90};
         w_d135 = {w_flags, w_fill_135};
      end
   end

   // column counter and hole counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_col      <= '0;
         r_hole_cnt <= '0;
      end else if (w_accept) begin
         r_col <= w_col_next;
         if (frame_start)
            r_hole_cnt <= {{(CNT_W-1){1'b0}}, ~w_good};
         else if (!w_good && (r_hole_cnt != c_cnt_max))
            r_hole_cnt <= r_hole_cnt + 1'b1;
      end
   end

`ifdef DIR_FILL_LEFT_EN
   // w_left already carries the column-0 clear, so flagged beats keep it
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_last_good <= '0;
      else if (w_accept)
         r_last_good <= w_good ? din[DWIDTH-1:0] : w_left;
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_s1_0     <= '0;
         r_s1_45    <= '0;
         r_s1_90    <= '0;
         r_s1_135   <= '0;
         r_s1_eol   <= 1'b0;
         r_s1_vld   <= 1'b0;
         r_dout_0   <= '0;
         r_dout_45  <= '0;
         r_dout_90  <= '0;
         r_dout_135 <= '0;
         r_eol      <= 1'b0;
         r_valid    <= 1'b0;
      end else if (w_accept) begin
         r_s1_0     <= w_d0;
         r_s1_45    <= w_d45;
         r_s1_90    <= w_d90;
         r_s1_135   <= w_d135;
         r_s1_eol   <= w_last;
         r_s1_vld   <= 1'b1;
         r_dout_0   <= r_s1_0;
         r_dout_45  <= r_s1_45;
         r_dout_90  <= r_s1_90;
         r_dout_135 <= r_s1_135;
         r_eol      <= r_s1_eol;
         r_valid    <= r_s1_vld;
      end
   end

   assign dout_0   = r_dout_0;
   assign dout_45  = r_dout_45;
   assign dout_90  = r_dout_90;
   assign dout_135 = r_dout_135;
   assign eol      = r_eol;
   assign valid    = r_valid;
   assign hole_cnt = r_hole_cnt;

endmodule

`default_nettype wire

// File: tb/tb_dir_fill_stage.sv
// ============================================================================
// Module   : tb_dir_fill_stage
// Purpose  : Directed self-checking bench for dir_fill_stage (IMG_W=4, CNT_W=3).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dir_fill_stage;

   localparam int DW = 7;
   localparam int BW = DW + 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          clken;
   logic          enable;
   logic          frame_start;
   logic [BW-1:0] din, din_ur, din_up, din_ul;
   logic [BW-1:0] dout_0, dout_45, dout_90, dout_135;
   logic          eol, valid;
   logic [2:0]    hole_cnt;

   int checks   = 0;
   int failures = 0;

   dir_fill_stage #(.DWIDTH(DW), .IMG_W(4), .CNT_W(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .clken      (clken),
      .enable     (enable),
      .frame_start(frame_start),
      .din        (din),
      .din_ur     (din_ur),
      .din_up     (din_up),
      .din_ul     (din_ul),
      .dout_0     (dout_0),
      .dout_45    (dout_45),
      .dout_90    (dout_90),
      .dout_135   (dout_135),
      .eol        (eol),
      .valid      (valid),
      .hole_cnt   (hole_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [BW-1:0] mk(input logic [1:0] f, input int d);
      return {f, DW'(d)};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk4(input string tag, input logic [BW-1:0] e0, e45, e90, e135);
      chk({tag, "_d0"},   32'(dout_0),   32'(e0));
      chk({tag, "_d45"},  32'(dout_45),  32'(e45));
      chk({tag, "_d90"},  32'(dout_90),  32'(e90));
      chk({tag, "_d135"}, 32'(dout_135), 32'(e135));
   endtask

   // one accepted beat; outputs are sampled 1 time unit after the edge
   task automatic beat(input logic [BW-1:0] d, ur, up, ul, input logic fs);
      clken = 1'b1; enable = 1'b1;
      din = d; din_ur = ur; din_up = up; din_ul = ul; frame_start = fs;
      @(posedge clk); #1;
   endtask

   logic [BW-1:0] e_b0;
   logic [BW-1:0] z;

   initial begin
      z = '0;
      rst = 1'b0; clken = 1'b0; enable = 1'b0; frame_start = 1'b0;
      din = '0; din_ur = '0; din_up = '0; din_ul = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_eol",   32'(eol),   32'd0);
      chk("rst_cnt",   32'(hole_cnt), 32'd0);
      chk4("rst", z, z, z, z);
      rst = 1'b1;
      @(posedge clk); #1;

      // good beats 5,6,7: two-beat latency
      beat(mk(2'b00, 5), z, z, z, 1'b1);
      chk("s1_valid_b1", 32'(valid), 32'd0);
      beat(mk(2'b00, 6), z, z, z, 1'b0);
      chk("s1_valid_b2", 32'(valid), 32'd1);
      chk4("s1_b2", mk(0, 5), mk(0, 5), mk(0, 5), mk(0, 5));
      beat(mk(2'b00, 7), z, z, z, 1'b0);
      chk4("s1_b3", mk(0, 6), mk(0, 6), mk(0, 6), mk(0, 6));
      chk("s1_cnt", 32'(hole_cnt), 32'd0);

      // new frame: good 10, then occluded pixel with mixed neighbours
      beat(mk(2'b00, 10), z, z, z, 1'b1);
      beat(mk(2'b01, 55), mk(2'b10, 30), mk(2'b00, 20), mk(2'b00, 40), 1'b0);
      chk("s2_cnt", 32'(hole_cnt), 32'd1);
`ifdef DIR_FILL_LEFT_EN
      e_b0 = mk(2'b01, 10);
`else
      e_b0 = mk(2'b01, 0);
`endif
      beat(mk(2'b00, 3), z, z, z, 1'b0);                                  // col 2
      chk4("s2", e_b0, mk(2'b01, 0), mk(2'b01, 20), mk(2'b01, 40));
      chk("s2_eol", 32'(eol), 32'd0);

      // last column flagged: 45 deg suppressed, eol set
      beat(mk(2'b10, 0), mk(0, 50), mk(0, 51), mk(0, 52), 1'b0);         // col 3
      // first column of next row flagged: 0 and 135 deg suppressed
      beat(mk(2'b01, 0), mk(0, 60), mk(0, 61), mk(0, 62), 1'b0);         // col 0
`ifdef DIR_FILL_LEFT_EN
      e_b0 = mk(2'b10, 3);
`else
      e_b0 = mk(2'b10, 0);
`endif
      chk4("s3_c3", e_b0, mk(2'b10, 0), mk(2'b10, 51), mk(2'b10, 52));
      chk("s3_c3_eol", 32'(eol), 32'd1);
      chk("s3_cnt", 32'(hole_cnt), 32'd3);
      beat(mk(2'b00, 12), z, z, z, 1'b0);                                 // col 1
      chk4("s3_c0", mk(2'b01, 0), mk(2'b01, 60), mk(2'b01, 61), mk(2'b01, 0));
      chk("s3_c0_eol", 32'(eol), 32'd0);

      // clken low with enable high: everything frozen
      clken = 1'b0; enable = 1'b1; frame_start = 1'b1;
      din = mk(2'b11, 99); din_ur = z; din_up = z; din_ul = z;
      repeat (5) @(posedge clk);
      #1;
      chk("frz_d0",  32'(dout_0),   32'(mk(2'b01, 0)));
      chk("frz_d90", 32'(dout_90),  32'(mk(2'b01, 61)));
      chk("frz_cnt", 32'(hole_cnt), 32'd3);
      chk("frz_vld", 32'(valid),    32'd1);
      beat(mk(2'b00, 13), z, z, z, 1'b0);                                 // col 2
      chk4("res_b1", mk(0, 12), mk(0, 12), mk(0, 12), mk(0, 12));
      beat(mk(2'b00, 14), z, z, z, 1'b0);                                 // col 3
      chk4("res_b2", mk(0, 13), mk(0, 13), mk(0, 13), mk(0, 13));
      chk("res_eol2", 32'(eol), 32'd0);
      beat(mk(2'b00, 15), z, z, z, 1'b0);                                 // col 0
      chk("res_d0_3", 32'(dout_0), 32'(mk(0, 14)));
      chk("res_eol3", 32'(eol), 32'd1);

      // hole counter saturation and frame_start reload
      beat(mk(2'b01, 1), z, z, z, 1'b1);
      chk("sat_1", 32'(hole_cnt), 32'd1);
      for (int i = 2; i <= 10; i++) begin
         beat(mk(2'b10, i), z, z, z, 1'b0);
         if (i == 6) chk("sat_6", 32'(hole_cnt), 32'd6);
      end
      chk("sat_10", 32'(hole_cnt), 32'd7);
      beat(mk(2'b00, 8), z, z, z, 1'b1);
      chk("sat_fs_good", 32'(hole_cnt), 32'd0);

      // asynchronous reset mid-row; next beat is column 0 without frame_start
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mrst_vld", 32'(valid), 32'd0);
      chk("mrst_cnt", 32'(hole_cnt), 32'd0);
      chk("mrst_d0",  32'(dout_0), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      beat(mk(2'b01, 0), mk(0, 69), mk(0, 71), mk(0, 70), 1'b0);
      chk("mrst_cnt1", 32'(hole_cnt), 32'd1);
      beat(mk(2'b00, 2), z, z, z, 1'b0);
      chk("mrst_vld2", 32'(valid), 32'd1);
      chk4("mrst", mk(2'b01, 0), mk(2'b01, 69), mk(2'b01, 71), mk(2'b01, 0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
